// File: rtl/card_game_ctrl.sv
// Memory-match game controller: 4x4 grid of cards, cursor navigation, pair
// selection, compare, mismatch hold timer, and game-over/restart handling.
module card_game_ctrl #(
  parameter logic [47:0] LAYOUT = {3'd7, 3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4,
                                   3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0},
  parameter int unsigned MISMATCH_HOLD = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [31:0] card_states,
  output logic [3:0]  cursor_pos,
  output logic [3:0]  match_count,
  output logic [7:0]  move_count,
  output logic        busy,
  output logic        game_over
);

  typedef enum logic [2:0] {PICK1, PICK2, COMPARE, HOLD, DONE} state_t;

  localparam logic [24:0] HOLD_LOAD = 25'(MISMATCH_HOLD - 1);

  state_t      state, state_nx;
  logic [31:0] cards_nx;
  logic [3:0]  cursor_nx, match_nx, first_idx, first_nx, second_idx, second_nx;
  logic [7:0]  moves_nx;
  logic [24:0] hold_cnt, hold_nx;
  logic [1:0]  row, col, cur_card;

  function automatic logic [2:0] face(input logic [3:0] idx);
    return LAYOUT[3*int'(idx) +: 3];
  endfunction

  assign row      = cursor_pos[3:2];
  assign col      = cursor_pos[1:0];
  assign cur_card = card_states[{cursor_pos, 1'b0} +: 2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PICK1;
      card_states <= '0;
      cursor_pos  <= '0;
      match_count <= '0;
      move_count  <= '0;
      first_idx   <= '0;
      second_idx  <= '0;
      hold_cnt    <= '0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nx;
      card_states <= cards_nx;
      cursor_pos  <= cursor_nx;
      match_count <= match_nx;
      move_count  <= moves_nx;
      first_idx   <= first_nx;
      second_idx  <= second_nx;
      hold_cnt    <= hold_nx;
      busy        <= (state_nx == COMPARE) || (state_nx == HOLD);
      game_over   <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx  = state;
    cards_nx  = card_states;
    cursor_nx = cursor_pos;
    match_nx  = match_count;
    moves_nx  = move_count;
    first_nx  = first_idx;
    second_nx = second_idx;
    hold_nx   = hold_cnt;
    case (state)
      PICK1, PICK2: begin
        // Select wins over any simultaneous move, even when the select is ignored.
        if (btn_sel) begin
          if (cur_card == 2'b00) begin
            cards_nx[{cursor_pos, 1'b0} +: 2] = 2'b01;
            if (state == PICK1) begin
              first_nx = cursor_pos;
              state_nx = PICK2;
            end else begin
              second_nx = cursor_pos;
              moves_nx  = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
              state_nx  = COMPARE;
            end
          end
        end else if (btn_up)    cursor_nx = {row - 2'd1, col};
        else if (btn_down)      cursor_nx = {row + 2'd1, col};
        else if (btn_left)      cursor_nx = {row, col - 2'd1};
        else if (btn_right)     cursor_nx = {row, col + 2'd1};
      end
      COMPARE: begin
        if (face(first_idx) == face(second_idx)) begin
          cards_nx[{first_idx, 1'b0} +: 2]  = 2'b10;
          cards_nx[{second_idx, 1'b0} +: 2] = 2'b10;
          match_nx = match_count + 4'd1;
          state_nx = (match_count == 4'd7) ? DONE : PICK1;
        end else begin
          hold_nx  = HOLD_LOAD;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          cards_nx[{first_idx, 1'b0} +: 2]  = 2'b00;
          cards_nx[{second_idx, 1'b0} +: 2] = 2'b00;
          state_nx = PICK1;
        end else begin
          hold_nx = hold_cnt - 25'd1;
        end
      end
      DONE: begin
        if (btn_sel) begin
          cards_nx  = '0;
          cursor_nx = '0;
          match_nx  = '0;
          moves_nx  = '0;
          state_nx  = PICK1;
        end
      end
      default: state_nx = PICK1;
    endcase
  end

endmodule

// File: tb/tb_card_game_ctrl.sv
// Directed bench for card_game_ctrl: expected output vectors go through a
// scoreboard queue and are checked one clock after the stimulus that causes them.
module tb_card_game_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [31:0] card_states;
  logic [3:0]  cursor_pos, match_count;
  logic [7:0]  move_count;
  logic        busy, game_over;

  typedef struct {
    string       tag;
    logic [49:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  card_game_ctrl #(.MISMATCH_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel),
    .card_states(card_states), .cursor_pos(cursor_pos), .match_count(match_count),
    .move_count(move_count), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] pk(input logic [31:0] c, input logic [3:0] cur,
                                     input logic [3:0] mc, input logic [7:0] mv,
                                     input logic b, input logic g);
    return {c, cur, mc, mv, b, g};
  endfunction

  // Cards of pairs 0..npairs-1 matched; pair fp (if >= 0) shown flipped.
  function automatic logic [31:0] pairs(input int npairs, input int fp);
    logic [31:0] c = '0;
    for (int k = 0; k < 16; k++) begin
      if (k / 2 < npairs) c[2*k +: 2] = 2'b10;
      else if (k / 2 == fp) c[2*k +: 2] = 2'b01;
    end
    return c;
  endfunction

  task automatic push(input string tag, input logic [49:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [49:0] obs;
    e = exp_q.pop_front();
    obs = {card_states, cursor_pos, match_count, move_count, busy, game_over};
    n_cmp++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed cards=%h cur=%0d mc=%0d mv=%0d busy=%b go=%b expected cards=%h cur=%0d mc=%0d mv=%0d busy=%b go=%b",
             e.tag, obs[49:18], obs[17:14], obs[13:10], obs[9:2], obs[1], obs[0],
             e.val[49:18], e.val[17:14], e.val[13:10], e.val[9:2], e.val[1], e.val[0]);
    end
  endtask

  // One clock with the given buttons pulsed; outputs settle #1 after the edge.
  task automatic cyc(input logic u, input logic d, input logic l, input logic r, input logic s);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
  endtask

  task automatic step(input logic u, input logic d, input logic l, input logic r, input logic s,
                      input string tag, input logic [49:0] v);
    push(tag, v);
    cyc(u, d, l, r, s);
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    push("reset_state", pk(32'h0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0));
    pop_check();
    @(negedge clk);
    reset = 1'b0;

    // Cursor wrap and move priority
    step(0,0,1,0,0, "left_wrap",   pk(32'h0, 4'd3,  4'd0, 8'd0, 0, 0));
    step(1,0,0,0,0, "up_wrap",     pk(32'h0, 4'd15, 4'd0, 8'd0, 0, 0));
    step(0,1,0,1,0, "down_prio",   pk(32'h0, 4'd3,  4'd0, 8'd0, 0, 0));
    step(1,1,1,1,0, "up_prio",     pk(32'h0, 4'd15, 4'd0, 8'd0, 0, 0));
    step(0,1,0,0,0, "down_wrap",   pk(32'h0, 4'd3,  4'd0, 8'd0, 0, 0));
    step(0,0,0,1,0, "right_wrap",  pk(32'h0, 4'd0,  4'd0, 8'd0, 0, 0));

    // Matching pair 0/1, plus ignored reselects
    step(0,0,0,0,1, "sel_first",   pk(32'h1, 4'd0, 4'd0, 8'd0, 0, 0));
    step(0,0,0,0,1, "sel_same",    pk(32'h1, 4'd0, 4'd0, 8'd0, 0, 0));
    step(0,0,0,1,0, "move_pick2",  pk(32'h1, 4'd1, 4'd0, 8'd0, 0, 0));
    step(0,0,0,0,1, "sel_second",  pk(32'h5, 4'd1, 4'd0, 8'd1, 1, 0));
    step(0,0,0,1,0, "compare_eq",  pk(32'hA, 4'd1, 4'd1, 8'd1, 0, 0));
    step(0,0,0,1,1, "sel_matched", pk(32'hA, 4'd1, 4'd1, 8'd1, 0, 0));

    // Mismatch 2 vs 4 with buttons hammered during COMPARE/HOLD
    cyc(0,0,0,1,0);
    step(0,0,0,0,1, "sel_card2",   pk(32'h1A,  4'd2, 4'd1, 8'd1, 0, 0));
    cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    step(0,0,0,0,1, "sel_card4",   pk(32'h11A, 4'd4, 4'd1, 8'd2, 1, 0));
    step(1,0,0,0,0, "hold1",       pk(32'h11A, 4'd4, 4'd1, 8'd2, 1, 0));
    step(0,0,0,0,1, "hold2",       pk(32'h11A, 4'd4, 4'd1, 8'd2, 1, 0));
    step(0,0,1,1,0, "hold3",       pk(32'h11A, 4'd4, 4'd1, 8'd2, 1, 0));
    step(0,1,0,0,1, "hold4",       pk(32'h11A, 4'd4, 4'd1, 8'd2, 1, 0));
    step(0,0,0,0,0, "hold_end",    pk(32'hA,   4'd4, 4'd1, 8'd2, 0, 0));
    step(0,0,0,0,0, "idle_pick1",  pk(32'hA,   4'd4, 4'd1, 8'd2, 0, 0));

    // Reset asserted in the middle of HOLD
    step(0,0,0,0,1, "sel_card4b",  pk(32'h10A, 4'd4, 4'd1, 8'd2, 0, 0));
    cyc(0,1,0,0,0);
    step(0,0,0,0,1, "sel_card8",   pk(32'h1010A, 4'd8, 4'd1, 8'd3, 1, 0));
    cyc(0,0,0,0,0);
    #2 reset = 1'b1;
    #1;
    push("reset_in_hold", pk(32'h0, 4'd0, 4'd0, 8'd0, 0, 0));
    pop_check();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0,0,0,0,1, "post_reset_sel", pk(32'h1, 4'd0, 4'd0, 8'd0, 0, 0));

    // Clear all eight pairs in order
    do_reset();
    for (int p = 0; p < 8; p++) begin
      cyc(0,0,0,0,1);
      cyc(0,0,0,1,0);
      step(0,0,0,0,1, "pair_flip",
           pk(pairs(p, p), 4'(2*p+1), 4'(p), 8'(p+1), 1, 0));
      step(0,0,0,0,0, "pair_match",
           pk(pairs(p+1, -1), 4'(2*p+1), 4'(p+1), 8'(p+1), 0, (p == 7)));
      if (p < 7) begin
        cyc(0,0,0,1,0);
        if (((2*p+1) & 3) == 3) cyc(0,1,0,0,0);
      end
    end
    step(0,0,1,0,0, "done_move",  pk(32'hAAAAAAAA, 4'd15, 4'd8, 8'd8, 0, 1));
    step(1,0,0,0,0, "done_move2", pk(32'hAAAAAAAA, 4'd15, 4'd8, 8'd8, 0, 1));
    step(0,0,0,0,1, "restart",    pk(32'h0, 4'd0, 4'd0, 8'd0, 0, 0));

    // Saturating move counter over repeated mismatches (card 0 vs card 4)
    for (int i = 0; i < 300; i++) begin
      cyc(0,0,0,0,1);
      cyc(0,1,0,0,0);
      cyc(0,0,0,0,1);
      repeat (5) cyc(0,0,0,0,0);
      if (i == 254)
        step(1,0,0,0,0, "moves_255", pk(32'h0, 4'd0, 4'd0, 8'd255, 0, 0));
      else
        cyc(1,0,0,0,0);
    end
    step(0,0,0,0,0, "moves_sat", pk(32'h0, 4'd0, 4'd0, 8'd255, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
